gap_accum: RTL and testbench
============================

// Module: gap_accum
// PURPOSE
// - Global-average-pool front end for the squeeze-excite path: accumulates 16 channel
//   lanes over one feature-map plane, then launches the 16-lane fixed-point divider array.
// - Issues the per-lane sums as dividends, with the plane pixel count as the common divisor.
// - Sits directly upstream of the divider array. Its outputs feed the divider's
//   start/dividends/divisor inputs, and the divider's done returns here.
// PARAMETERS
// - WIDTH      14  signed lane width of input pixels and output dividends (FBITS fractional)
// - FBITS       7  fractional bits of in_data/dividends (format pass-through, no shift applied)
// - BWIDTH     12  width of pixel count / divisor (unsigned, max 4095)
// - ACC_WIDTH  WIDTH+BWIDTH  internal signed accumulator width per lane
// PORTS
// - clk         in   1          single clock, rising edge
// - rst         in   1          asynchronous, active-high reset
// - cfg_pixels  in   BWIDTH     pixels per plane (H*W); sampled on first accepted beat of a plane
// - in_valid    in   1          input beat valid
// - in_ready    out  1          block can accept a beat
// - in_data     in   16*WIDTH   16 signed pixels, lane i at [WIDTH*(i+1)-1:WIDTH*i]
// - div_start   out  1          one-cycle launch pulse to divider array
// - dividends   out  16*WIDTH   per-lane plane sums, same packing as in_data
// - divisor     out  BWIDTH     latched plane pixel count
// - div_done    in   1          divider array completion (AND of all lanes)
// - plane_done  out  1          one-cycle pulse when divider results for a plane are valid
// BEHAVIOUR
// - States: ACC -> ISSUE -> WAIT -> ACC.
//   - in_ready = (state==ACC); it is combinational from state.
// - Reset (async): state=ACC; accumulators=0; pixel count=0.
//   - div_start=0, dividends=0, divisor=0, plane_done=0; in_ready=1 after reset.
// - ACC: on in_valid&&in_ready, each lane adds sign-extended in_data lane to its accumulator.
//   - The first beat of a plane (count==0) latches cfg_pixels into divisor.
//   - cfg_pixels==0 is latched as 1.
//   - When count==divisor-1 on an accepted beat: the beat is accumulated, the state moves
//     to ISSUE, and count clears. A plane of N pixels leaves ACC after exactly N beats.
// - ISSUE (1 cycle): div_start=1; dividends register the converted accumulators; go to WAIT.
//   - Registering happens here, so div_start and the new dividends are visible in the same cycle.
// - WAIT: dividends and divisor are held stable.
//   - div_done is ignored in the first WAIT cycle, to skip a stale done from the previous op.
//   - From the 2nd WAIT cycle, div_done=1 -> plane_done pulses for one cycle, accumulators
//     clear, and the state returns to ACC. The next beat is accepted the following cycle.
// - in_valid outside ACC is ignored (no accept). The upstream producer holds data per valid/ready.
// - Conversion ACC_WIDTH->WIDTH: see CONFIGURATION. The fractional point is unchanged
//   (sum keeps FBITS).
// - Reset mid-plane or mid-WAIT: the plane is discarded; the block returns to ACC with zeroed state.
// - Latency: last beat accepted at cycle t -> div_start at t+1 -> earliest plane_done at t+3.
// CONFIGURATION
// - Macro GAP_SAT_EN.
// - Defined: each lane saturates to the signed WIDTH range.
//   - Sum > 2^(WIDTH-1)-1 -> 0x1FFF.
//   - Sum < -2^(WIDTH-1) -> 0x2000 (defaults).
// - Undefined: each lane takes the low WIDTH bits of the accumulator (two's-complement wrap).
// - The accumulator itself never wraps in legal use: ACC_WIDTH covers 4095 beats of full-scale input.
// TESTING
// - cfg_pixels=4, lanes all +1.0 (0x080) x4 beats -> div_start once, every lane 0x200,
//   divisor=4, in_ready low 2+ cycles.
// - cfg_pixels=2, lane0 = +0x1FFF twice, lane1 = -0x2000 twice.
//   - GAP_SAT_EN: lane0=0x1FFF, lane1=0x2000.
//   - Without the macro: lane0=0x3FFE, lane1=0x0000.
// - div_done held high throughout WAIT -> plane_done must pulse on 2nd WAIT cycle, not 1st;
//   single pulse.
// - in_valid toggling 1-0-1-0, cfg_pixels=3 -> only accepted beats counted; issue after 3rd accept.
// - rst asserted after 2 of 4 beats -> all outputs 0, in_ready=1.
//   - A fresh 4-beat plane of 0x080 then gives 0x200, not 0x300.
// - cfg_pixels=0 -> divisor=1, single beat triggers ISSUE with dividends = that beat.

Source files
------------

// File: rtl/gap_accum.sv
// Global-average-pool front end: sums 16 signed lanes over one plane, then launches the divider array.
// Optional macro GAP_SAT_EN selects saturating (instead of wrapping) narrowing of the plane sums.
module gap_accum #(
   parameter int WIDTH     = 14,
   parameter int FBITS     = 7,
   parameter int BWIDTH    = 12,
   parameter int ACC_WIDTH = WIDTH + BWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BWIDTH-1:0]     cfg_pixels,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WIDTH-1:0]   in_data,
   output logic                  div_start,
   output logic [16*WIDTH-1:0]   dividends,
   output logic [BWIDTH-1:0]     divisor,
   input  logic                  div_done,
   output logic                  plane_done
);

   localparam int LANES = 16;

`ifdef GAP_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (WIDTH-1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

   typedef enum logic [1:0] {ACC, ISSUE, WAIT} state_t;

   state_t                       state, state_next;
   logic signed [ACC_WIDTH-1:0]  acc     [LANES];
   logic signed [ACC_WIDTH-1:0]  acc_sum [LANES];
   logic [BWIDTH-1:0]            count;
   logic [BWIDTH-1:0]            cfg_eff;
   logic [BWIDTH-1:0]            div_eff;
   logic [16*WIDTH-1:0]          conv;
   logic                         wait_first;
   logic                         accept;
   logic                         last_beat;
   logic                         done_seen;

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // the producer holds in_data stable while in_valid is high and in_ready is low.
   assign in_ready = (state == ACC);

   always_comb begin
      accept    = in_valid && (state == ACC);
      cfg_eff   = (cfg_pixels == '0) ? BWIDTH'(1) : cfg_pixels;
      // The first beat compares against the fresh cfg value, not the stale latched divisor.
      div_eff   = (count == '0) ? cfg_eff : divisor;
      last_beat = accept && (count == div_eff - BWIDTH'(1));
      // The first WAIT cycle may still see the previous operation's done.
      done_seen = (state == WAIT) && !wait_first && div_done;
      plane_done = done_seen;
   end

   always_comb begin
      conv = '0;
      for (int i = 0; i < LANES; i++) begin
         acc_sum[i] = acc[i] + {{(ACC_WIDTH-WIDTH){in_data[WIDTH*i+WIDTH-1]}},
                                in_data[WIDTH*i +: WIDTH]};
`ifdef GAP_SAT_EN
         if (acc_sum[i] > SAT_MAX)
            conv[WIDTH*i +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
         else if (acc_sum[i] < SAT_MIN)
            conv[WIDTH*i +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
         else
            conv[WIDTH*i +: WIDTH] = acc_sum[i][WIDTH-1:0];
`else
         conv[WIDTH*i +: WIDTH] = acc_sum[i][WIDTH-1:0];
`endif
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACC:     if (last_beat) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (done_seen) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ACC;
         count      <= '0;
         divisor    <= '0;
         dividends  <= '0;
         div_start  <= 1'b0;
         wait_first <= 1'b0;
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
         state      <= state_next;
         wait_first <= (state == ISSUE);
         // Dividends load with the last beat so they line up with div_start in the ISSUE cycle.
         div_start  <= last_beat;
         if (last_beat) dividends <= conv;
         if (accept) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc_sum[i];
            if (count == '0) divisor <= cfg_eff;
            count <= last_beat ? '0 : count + BWIDTH'(1);
         end
         if (done_seen) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_gap_accum.sv
// Self-checking bench for gap_accum: directed scenarios plus random planes against an integer-sum model.
// Build with +define+GAP_SAT_EN to check the saturating variant.
module tb_gap_accum;

   localparam int WIDTH  = 14;
   localparam int BWIDTH = 12;
   localparam int LANES  = 16;
   localparam int DW     = LANES * WIDTH;

   logic              clk = 1'b0;
   logic              rst;
   logic [BWIDTH-1:0] cfg_pixels;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              div_start;
   logic [DW-1:0]     dividends;
   logic [BWIDTH-1:0] divisor;
   logic              div_done;
   logic              plane_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] beat_q[$];
   logic [DW-1:0] exp_q[$];

   gap_accum dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_pixels (cfg_pixels),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .div_start  (div_start),
      .dividends  (dividends),
      .divisor    (divisor),
      .div_done   (div_done),
      .plane_done (plane_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [WIDTH-1:0] to_lane(input int s);
`ifdef GAP_SAT_EN
      if (s > 8191) return 14'h1FFF;
      if (s < -8192) return 14'h2000;
`endif
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [DW-1:0] model_plane();
      int sums[LANES];
      logic [DW-1:0] r;
      logic signed [WIDTH-1:0] l;
      for (int i = 0; i < LANES; i++) sums[i] = 0;
      foreach (beat_q[b])
         for (int i = 0; i < LANES; i++) begin
            l = beat_q[b][i*WIDTH +: WIDTH];
            sums[i] = sums[i] + int'(l);
         end
      for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = to_lane(sums[i]);
      return r;
   endfunction

   function automatic logic [DW-1:0] splat(input logic [WIDTH-1:0] v);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 16383));
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_beat(input logic [DW-1:0] d, output bit ok);
      bit r;
      in_valid = 1'b1;
      in_data  = d;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         if (r) ok = 1'b1;
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends every beat in beat_q; returns just after the edge that accepts the last one.
   task automatic push_plane(input int cfg, input int gap_max, output bit ok);
      bit b_ok;
      cfg_pixels = BWIDTH'(cfg);
      exp_q.push_back(model_plane());
      ok = 1'b1;
      foreach (beat_q[b]) begin
         send_beat(beat_q[b], b_ok);
         ok = ok && b_ok;
         if (gap_max > 0 && b != beat_q.size() - 1) idle($urandom_range(0, gap_max));
      end
   endtask

   // Observes cycles from ISSUE onward; div_done rises at cycle k.
   task automatic finish_plane(input int k, output int pd_at, output int starts, output bit start0,
                               output logic [DW-1:0] div0, output logic [BWIDTH-1:0] dvs0,
                               output int ready_low, output bit hold_bad);
      pd_at = -1; starts = 0; ready_low = 0; hold_bad = 1'b0; start0 = 1'b0;
      div0 = '0; dvs0 = '0;
      for (int n = 0; n < 16; n++) begin
         div_done = (n >= k);
         @(negedge clk);
         if (n == 0) begin
            start0 = div_start; div0 = dividends; dvs0 = divisor;
         end else if (dividends !== div0 || divisor !== dvs0) hold_bad = 1'b1;
         if (div_start === 1'b1) starts++;
         if (in_ready !== 1'b1) ready_low++;
         if (plane_done === 1'b1 && pd_at < 0) pd_at = n;
         @(posedge clk);
         #1;
         if (pd_at >= 0) break;
      end
      div_done = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_pixels = '0; div_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (div_start !== 1'b0) begin miscompares++; $display("FAIL reset_div_start got %b want 0", div_start); end
      vectors++; if (dividends !== '0) begin miscompares++; $display("FAIL reset_dividends got %h want 0", dividends); end
      vectors++; if (divisor !== '0) begin miscompares++; $display("FAIL reset_divisor got %h want 0", divisor); end
      vectors++; if (plane_done !== 1'b0) begin miscompares++; $display("FAIL reset_plane_done got %b want 0", plane_done); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      beat_q.delete();
      repeat (4) beat_q.push_back(splat(14'h080));
      push_plane(4, 0, ok);
      finish_plane(3, pd, st, s0, d0, v0, rl, hb);
      e = exp_q.pop_front();
      vectors++; if (!ok) begin miscompares++; $display("FAIL basic_accept got timeout want accepted"); end
      vectors++; if (d0 !== splat(14'h200)) begin miscompares++; $display("FAIL basic_const got %h want %h", d0, splat(14'h200)); end
      vectors++; if (d0 !== e) begin miscompares++; $display("FAIL basic_model got %h want %h", d0, e); end
      vectors++; if (v0 !== 12'd4) begin miscompares++; $display("FAIL basic_divisor got %0d want 4", v0); end
      vectors++; if (!s0 || st != 1) begin miscompares++; $display("FAIL basic_start got start0=%b count=%0d want 1/1", s0, st); end
      vectors++; if (pd != 3 || rl != 4) begin miscompares++; $display("FAIL basic_done got pd=%0d ready_low=%0d want 3/4", pd, rl); end
      vectors++; if (hb) begin miscompares++; $display("FAIL basic_hold got unstable want stable"); end
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1 || plane_done !== 1'b0) begin miscompares++; $display("FAIL basic_after got ready=%b pd=%b want 1/0", in_ready, plane_done); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, b, e; logic [BWIDTH-1:0] v0;
      logic [WIDTH-1:0] w0, w1;
      b = '0; b[0 +: WIDTH] = 14'h1FFF; b[WIDTH +: WIDTH] = 14'h2000;
      beat_q.delete(); beat_q.push_back(b); beat_q.push_back(b);
`ifdef GAP_SAT_EN
      w0 = 14'h1FFF; w1 = 14'h2000;
`else
      w0 = 14'h3FFE; w1 = 14'h0000;
`endif
      push_plane(2, 0, ok);
      finish_plane(2, pd, st, s0, d0, v0, rl, hb);
      e = exp_q.pop_front();
      vectors++; if (d0[0 +: WIDTH] !== w0) begin miscompares++; $display("FAIL ovf_lane0 got %h want %h", d0[0 +: WIDTH], w0); end
      vectors++; if (d0[WIDTH +: WIDTH] !== w1) begin miscompares++; $display("FAIL ovf_lane1 got %h want %h", d0[WIDTH +: WIDTH], w1); end
      vectors++; if (d0 !== e) begin miscompares++; $display("FAIL ovf_model got %h want %h", d0, e); end
      vectors++; if (v0 !== 12'd2 || pd != 2 || !ok) begin miscompares++; $display("FAIL ovf_ctrl got div=%0d pd=%0d ok=%b want 2/2/1", v0, pd, ok); end
      @(negedge clk); @(posedge clk); #1;
   endtask

   task automatic test_done_held();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      beat_q.delete();
      repeat (3) beat_q.push_back(rand_beat());
      div_done = 1'b1;
      push_plane(3, 1, ok);
      finish_plane(0, pd, st, s0, d0, v0, rl, hb);
      e = exp_q.pop_front();
      vectors++; if (pd != 2) begin miscompares++; $display("FAIL held_pd_cycle got %0d want 2", pd); end
      vectors++; if (d0 !== e) begin miscompares++; $display("FAIL held_model got %h want %h", d0, e); end
      div_done = 1'b1;
      @(negedge clk);
      vectors++; if (plane_done !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL held_single got pd=%b ready=%b want 0/1", plane_done, in_ready); end
      @(posedge clk); #1;
      div_done = 1'b0;
   endtask

   task automatic test_valid_toggle();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      beat_q.delete();
      repeat (3) beat_q.push_back(rand_beat());
      cfg_pixels = 12'd3;
      e = model_plane();
      for (int b = 0; b < 3; b++) begin
         send_beat(beat_q[b], ok);
         if (b < 2) begin
            @(negedge clk);
            vectors++; if (div_start !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL toggle_early beat=%0d got start=%b ready=%b want 0/1", b, div_start, in_ready); end
            @(posedge clk); #1;
         end
      end
      finish_plane(4, pd, st, s0, d0, v0, rl, hb);
      vectors++; if (!s0 || st != 1 || v0 !== 12'd3) begin miscompares++; $display("FAIL toggle_issue got start0=%b n=%0d div=%0d want 1/1/3", s0, st, v0); end
      vectors++; if (d0 !== e || pd != 4 || hb) begin miscompares++; $display("FAIL toggle_result got %h pd=%0d want %h pd=4", d0, pd, e); end
      @(negedge clk); @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      cfg_pixels = 12'd4;
      send_beat(splat(14'h080), ok);
      send_beat(splat(14'h080), ok);
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1 || divisor !== '0) begin miscompares++; $display("FAIL rstmid_async got ready=%b div=%0d want 1/0", in_ready, divisor); end
      vectors++; if (dividends !== '0 || div_start !== 1'b0 || plane_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_outs got %h start=%b pd=%b want 0", dividends, div_start, plane_done); end
      @(posedge clk); #1 rst = 1'b0;
      beat_q.delete();
      repeat (4) beat_q.push_back(splat(14'h080));
      push_plane(4, 0, ok);
      finish_plane(2, pd, st, s0, d0, v0, rl, hb);
      e = exp_q.pop_front();
      vectors++; if (d0 !== splat(14'h200)) begin miscompares++; $display("FAIL rstmid_fresh got %h want %h", d0, splat(14'h200)); end
      vectors++; if (d0 !== e || !s0) begin miscompares++; $display("FAIL rstmid_model got %h start0=%b want %h/1", d0, s0, e); end
      @(negedge clk); @(posedge clk); #1;
   endtask

   task automatic test_cfg_zero();
      bit ok, s0, hb; int pd, st, rl; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      beat_q.delete();
      beat_q.push_back(rand_beat());
      push_plane(0, 0, ok);
      finish_plane(1, pd, st, s0, d0, v0, rl, hb);
      e = exp_q.pop_front();
      vectors++; if (v0 !== 12'd1) begin miscompares++; $display("FAIL cfg0_divisor got %0d want 1", v0); end
      vectors++; if (d0 !== beat_q[0] || d0 !== e) begin miscompares++; $display("FAIL cfg0_dividends got %h want %h", d0, e); end
      vectors++; if (!s0 || st != 1 || pd != 2) begin miscompares++; $display("FAIL cfg0_ctrl got start0=%b n=%0d pd=%0d want 1/1/2", s0, st, pd); end
      @(negedge clk); @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit ok, s0, hb; int pd, st, rl, cfg, k, exp_pd; logic [DW-1:0] d0, e; logic [BWIDTH-1:0] v0;
      for (int p = 0; p < 8; p++) begin
         cfg = $urandom_range(1, 6);
         k   = $urandom_range(0, 4);
         exp_pd = (k > 2) ? k : 2;
         beat_q.delete();
         repeat (cfg) beat_q.push_back(rand_beat());
         push_plane(cfg, 2, ok);
         finish_plane(k, pd, st, s0, d0, v0, rl, hb);
         e = exp_q.pop_front();
         vectors++; if (d0 !== e || !ok) begin miscompares++; $display("FAIL rand_dividends plane=%0d got %h want %h", p, d0, e); end
         vectors++; if (v0 !== BWIDTH'(cfg) || hb) begin miscompares++; $display("FAIL rand_divisor plane=%0d got %0d want %0d", p, v0, cfg); end
         vectors++; if (!s0 || st != 1) begin miscompares++; $display("FAIL rand_start plane=%0d got start0=%b n=%0d want 1/1", p, s0, st); end
         vectors++; if (pd != exp_pd || rl != exp_pd + 1) begin miscompares++; $display("FAIL rand_done plane=%0d got pd=%0d ready_low=%0d want %0d/%0d", p, pd, rl, exp_pd, exp_pd + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_done_held();
      test_valid_toggle();
      test_reset_mid();
      test_cfg_zero();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
